nested_squares: RTL and testbench
=================================

Name: nested_squares

Overview:
Iterative inverse of the nested-radical square-root engine. Given root y and offsets a and b, it computes c = ((y^2 - a)^2 - b)^2, so that y = sqrt(a + sqrt(b + sqrt(c))). All three squarings run on one shared shift-add multiplier under FSM control. The block generates test operands for the radical engine and acts as its round-trip checker.

Parameters:
WIDTH, 16, width of a, b and c. Must be even and at least 4. HALF = WIDTH/2 is the width of y and of every multiplier operand.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  request pulse; sampled only in IDLE
y  in  HALF  root value; captured on the start edge
a  in  WIDTH  outer offset; captured on the start edge
b  in  WIDTH  inner offset; captured on the start edge
busy  out  1  high while the state is not IDLE
result_valid  out  1  one-cycle pulse; c and flags are valid from this cycle
c  out  WIDTH  result; held until the next accepted start
underflow  out  1  a subtraction went negative; held like c
overflow  out  1  a difference did not fit in HALF bits; held like c

Behaviour:
- Reset (async): state=IDLE. busy=0, result_valid=0, c=0, underflow=0, overflow=0. Internal registers cleared. Reset mid-operation aborts the computation; no result_valid is produced.
- States:
  - IDLE: start=1 captures y, a, b; multiplicand=multiplier=y; pass=0; c and flags cleared; next state MUL. While busy, start is ignored.
  - MUL: HALF cycles, one multiplier bit per cycle, LSB first. Product accumulates in a WIDTH-bit register, which cannot overflow since operands are HALF bits. After HALF cycles: next state SUB if pass<2, else DONE with c <= product.
  - SUB (1 cycle): d = product - (pass==0 ? a : b), computed at WIDTH+1 bits.
    - d negative: underflow=1, c=0, next state DONE.
    - else d >= 2^HALF: overflow=1, c=0, next state DONE.
    - else: multiplicand=multiplier=d[HALF-1:0]; pass++; next state MUL.
  - DONE (1 cycle): result_valid=1; next state IDLE.
- result_valid is registered and equals (state==DONE).
- Latency, counted in clock edges from the start-sampling edge to the edge that raises result_valid:
  - normal: 3*HALF+2 (26 at WIDTH=16)
  - abort in first SUB: HALF+1
  - abort in second SUB: 2*HALF+2
- Boundaries:
  - y=0 is legal.
  - d=0 is legal and gives c=0 with no flag.
  - d = 2^HALF-1 is legal.
  - start held high continuously: a new computation begins on the cycle after DONE, since IDLE samples it.

Optional Feature:
NESTED_SQUARES_SAT_EN.
- Defined: errors saturate and computation continues instead of aborting.
  - Negative d is clamped to 0, with underflow=1.
  - d >= 2^HALF is clamped to 2^HALF-1, with overflow=1.
  - Flags are sticky for the whole run.
  - Latency is always 3*HALF+2.
- Undefined: the abort behaviour described above.

Test Plan:
- WIDTH=16, y=3, a=5, b=2, start pulse -> result_valid 26 edges later; c=196, underflow=0, overflow=0; busy high throughout.
- y=2, a=5 -> result_valid after 9 edges; c=0, underflow=1. With NESTED_SQUARES_SAT_EN: c=0, underflow=1, latency 26.
- y=255, a=0 -> d1=65025 >= 256; after 9 edges overflow=1, c=0. With SAT_EN: d1 clamps to 255, and b=0 gives c=((255^2) mod 2^16 clamped path), with overflow=1 and latency 26.
- y=3, a=5, b=20 -> d1=4, s2=16, 16-20<0; after 18 edges underflow=1, c=0.
- Start pulse at edge 5 of a running computation is ignored; first result is still c=196 at edge 26. Reset asserted at edge 10 -> busy=0 and c=0 immediately, no result_valid, next start works normally.
- Back-to-back: start held high, operands y=3, a=5, b=2 -> two result_valid pulses 28 edges apart, both with c=196.

Source files
------------

// File: rtl/nested_squares.sv
// nested_squares
//   Iterative inverse of the nested-radical square-root engine. From a root y
//   and offsets a and b it computes c = ((y^2 - a)^2 - b)^2, so that
//   y = sqrt(a + sqrt(b + sqrt(c))). The three squarings share one LSB-first
//   shift-add multiplier that retires one multiplier bit per cycle.
//
//   Optional feature macro: NESTED_SQUARES_SAT_EN
//     defined   : a negative difference clamps to 0 (underflow), a difference
//                 >= 2^HALF clamps to 2^HALF-1 (overflow); flags are sticky and
//                 every run takes 3*HALF+2 cycles.
//     undefined : the first bad difference aborts the run with c = 0.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   start        in   request pulse, sampled only while idle
//   y            in   [HALF-1:0] root, captured on the start edge
//   a, b         in   [WIDTH-1:0] offsets, captured on the start edge
//   busy         out  high while a computation is in flight
//   result_valid out  one-cycle pulse; c and flags are valid from this cycle
//   c            out  [WIDTH-1:0] result, held until the next accepted start
//   underflow    out  a difference went negative
//   overflow     out  a difference did not fit in HALF bits

module nested_squares #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH/2-1:0] y,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               result_valid,
  output logic [WIDTH-1:0]   c,
  output logic               underflow,
  output logic               overflow
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF) + 1;

  typedef enum logic [1:0] {IDLE, MUL, SUB, DONE} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        a_q, a_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic [WIDTH-1:0]        mcand_q, mcand_d;
  logic [HALF-1:0]         mplier_q, mplier_d;
  logic [WIDTH-1:0]        prod_q, prod_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0]              pass_q, pass_d;
  logic [WIDTH-1:0]        c_q, c_d;
  logic                    unf_q, unf_d;
  logic                    ovf_q, ovf_d;
  logic                    rv_q, rv_d;

  logic                    mul_last;
  logic [WIDTH-1:0]        prod_next;
  logic [WIDTH-1:0]        sub_sel;
  logic signed [WIDTH:0]   sub_d;
  logic                    d_neg;
  logic                    d_big;
  logic [HALF-1:0]         d_half;

  // Product cannot wrap: both operands are HALF bits wide.
  assign mul_last  = (state_q == MUL) && (cnt_q == CW'(HALF - 1));
  assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

  // One extra bit so a negative difference is visible in the sign.
  assign sub_sel = (pass_q == 2'd0) ? a_q : b_q;
  assign sub_d   = $signed({1'b0, prod_q}) - $signed({1'b0, sub_sel});
  assign d_neg   = sub_d[WIDTH];
  assign d_big   = !d_neg && (|sub_d[WIDTH-1:HALF]);

  // Operand for the next squaring; only meaningful without abort.
  always_comb begin
    d_half = sub_d[HALF-1:0];
    if (d_neg)      d_half = '0;
    else if (d_big) d_half = '1;
  end

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      pass_q   <= '0;
      c_q      <= '0;
      unf_q    <= 1'b0;
      ovf_q    <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      c_q      <= c_d;
      unf_q    <= unf_d;
      ovf_q    <= ovf_d;
      rv_q     <= rv_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = MUL;
      MUL:  if (mul_last) state_d = (pass_q != 2'd2) ? SUB : DONE;
`ifdef NESTED_SQUARES_SAT_EN
      SUB:  state_d = MUL;
`else
      SUB:  state_d = (d_neg || d_big) ? DONE : MUL;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    c_d      = c_q;
    unf_d    = unf_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          mcand_d  = WIDTH'(y);
          mplier_d = y;
          prod_d   = '0;
          cnt_d    = '0;
          pass_d   = 2'd0;
          c_d      = '0;
          unf_d    = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      MUL: begin
        prod_d   = prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (mul_last && (pass_q == 2'd2)) c_d = prod_next;
      end
      SUB: begin
`ifdef NESTED_SQUARES_SAT_EN
        unf_d = unf_q | d_neg;
        ovf_d = ovf_q | d_big;
`else
        if (d_neg) begin
          unf_d = 1'b1;
          c_d   = '0;
        end else if (d_big) begin
          ovf_d = 1'b1;
          c_d   = '0;
        end
`endif
        mcand_d  = WIDTH'(d_half);
        mplier_d = d_half;
        prod_d   = '0;
        cnt_d    = '0;
        pass_d   = pass_q + 2'd1;
      end
      default: ;
    endcase
    rv_d = (state_d == DONE);
  end

  // Outputs
  always_comb begin
    busy         = (state_q != IDLE);
    result_valid = rv_q;
    c            = c_q;
    underflow    = unf_q;
    overflow     = ovf_q;
  end

endmodule

// File: tb/tb_nested_squares.sv
module tb_nested_squares;

  localparam int W = 16;
  localparam int H = W / 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [H-1:0] y_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy, rv, unf, ovf;
  logic [W-1:0] c_o;

  int total = 0;
  int bad = 0;

  nested_squares #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y_i), .a(a_i), .b(b_i),
    .busy(busy), .result_valid(rv), .c(c_o), .underflow(unf), .overflow(ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic straight from the formula.
  function automatic void model(input longint y, input longint a, input longint b,
                                output longint c, output bit u, output bit o,
                                output int lat);
    longint s, d;
    u = 1'b0; o = 1'b0;
    s = y * y;
    for (int p = 0; p < 2; p++) begin
      d = s - ((p == 0) ? a : b);
      if (d < 0) begin
        u = 1'b1;
`ifdef NESTED_SQUARES_SAT_EN
        d = 0;
`else
        c = 0; lat = (p + 1) * (H + 1); return;
`endif
      end else if (d >= (64'd1 << H)) begin
        o = 1'b1;
`ifdef NESTED_SQUARES_SAT_EN
        d = (64'd1 << H) - 1;
`else
        c = 0; lat = (p + 1) * (H + 1); return;
`endif
      end
      s = d * d;
    end
    c = s;
    lat = 3 * H + 2;
  endfunction

  // Timeline model: 0 idle, 1 running, 2 result cycle.
  int     m_phase = 0;
  int     m_rem = 0;
  int     m_done_cnt = 0;
  longint m_c = 0, p_c;
  bit     m_u = 0, m_o = 0, p_u, p_o;
  int     p_lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_c = 0; m_u = 0; m_o = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          model(longint'(y_i), longint'(a_i), longint'(b_i), p_c, p_u, p_o, p_lat);
          m_rem = p_lat; m_phase = 1; m_c = 0; m_u = 0; m_o = 0;
        end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = 2; m_c = p_c; m_u = p_u; m_o = p_o; m_done_cnt++;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  // Single compare process: model pins once, then DUT vs model every cycle.
  bit pinned = 0;
  always @(negedge clk) begin
    longint pc; bit pu, po; int pl;
    if (!pinned) begin
      pinned = 1;
`ifdef NESTED_SQUARES_SAT_EN
      model(3, 5, 2, pc, pu, po, pl);    check("pin1_c", pc, 196); check("pin1_lat", pl, 26);
      model(2, 5, 2, pc, pu, po, pl);    check("pin2_c", pc, 0);   check("pin2_u", pu, 1); check("pin2_lat", pl, 26);
      model(255, 0, 0, pc, pu, po, pl);  check("pin3_c", pc, 65025); check("pin3_o", po, 1);
      model(3, 5, 20, pc, pu, po, pl);   check("pin4_c", pc, 0);   check("pin4_u", pu, 1);
`else
      model(3, 5, 2, pc, pu, po, pl);    check("pin1_c", pc, 196); check("pin1_lat", pl, 26);
      model(2, 5, 2, pc, pu, po, pl);    check("pin2_u", pu, 1);   check("pin2_lat", pl, 9);
      model(255, 0, 0, pc, pu, po, pl);  check("pin3_o", po, 1);   check("pin3_lat", pl, 9);
      model(3, 5, 20, pc, pu, po, pl);   check("pin4_u", pu, 1);   check("pin4_lat", pl, 18);
`endif
      model(16, 1, 64770, pc, pu, po, pl); check("pin5_c", pc, 65025); check("pin5_f", {pu, po}, 0);
    end
    check("busy", busy, m_phase != 0);
    check("result_valid", rv, m_phase == 2);
    check("c", c_o, m_c);
    check("underflow", unf, m_u);
    check("overflow", ovf, m_o);
  end

  task automatic wait_idle();
    int n = 0;
    while (m_phase != 0 && n < 200) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic op(input logic [H-1:0] y, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    y_i = y; a_i = a; b_i = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    y_i = H'($urandom); a_i = W'($urandom); b_i = W'($urandom);
    wait_idle();
  endtask

  initial begin
    int base;
    logic [H-1:0] ry;
    longint s1, d1, ra, rb;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    op(3, 5, 2);
    op(2, 5, 2);
    op(255, 0, 0);
    op(3, 5, 20);
    op(0, 0, 0);          // y = 0
    op(3, 9, 0);          // d = 0 twice
    op(16, 1, 64770);     // d = 2^HALF-1 on both passes
    op(16, 0, 0);         // d = 2^HALF

    // Start pulse mid-run is ignored.
    @(negedge clk);
    y_i = 3; a_i = 5; b_i = 2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    y_i = 7; a_i = 1; b_i = 1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-run, then a normal run.
    @(negedge clk);
    y_i = 3; a_i = 5; b_i = 2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    op(3, 5, 2);

    // Start held high: back-to-back runs.
    @(negedge clk);
    y_i = 3; a_i = 5; b_i = 2; start = 1'b1;
    base = m_done_cnt;
    for (int n = 0; n < 200 && m_done_cnt < base + 2; n++) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Randomized runs steered around the flag boundaries.
    for (int i = 0; i < 40; i++) begin
      ry = H'($urandom);
      s1 = longint'(ry) * ry;
      case ($urandom_range(0, 2))
        0: ra = $urandom_range(0, 65535);
        1: ra = (s1 > 300) ? s1 - $urandom_range(0, 300) : $urandom_range(0, 300);
        default: ra = (s1 > 5) ? s1 - $urandom_range(0, 5) + $urandom_range(0, 3) : 0;
      endcase
      d1 = s1 - ra;
      if (d1 >= 0 && d1 < 256 && $urandom_range(0, 1) == 1)
        rb = d1 * d1 - $urandom_range(0, 260) + $urandom_range(0, 3);
      else
        rb = $urandom_range(0, 65535);
      if (rb < 0) rb = 0;
      if (rb > 65535) rb = 65535;
      op(ry, W'(ra), W'(rb));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
